// File: rtl/gate_pipe_if.sv
// Operand/result handshake bundle for gate_pipe.
// The y_par signal exists only when GATE_PIPE_PARITY_EN is defined.
interface gate_pipe_if #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [1:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;
  logic [CNT_W-1:0] count;
`ifdef GATE_PIPE_PARITY_EN
  logic             y_par;

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, y, count, y_par
  );
  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, y, count, y_par
  );
`else
  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, y, count
  );
  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, y, count
  );
`endif
endinterface

// File: rtl/gate_pipe.sv
// Bitwise logic unit (AND/OR/XOR/NAND) feeding a show-ahead result FIFO.
// Optional feature: define GATE_PIPE_PARITY_EN to store and present y_par.
module gate_pipe #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  gate_pipe_if.slave  bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] result;
  logic             in_ready;
  logic             out_valid;
  logic             accept;
  logic             pop;

  // Per-bit 4:1 lookup indexed directly by op.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    logic [3:0] lut;
    assign lut = {~(bus.a[gi] & bus.b[gi]), bus.a[gi] ^ bus.b[gi],
                  bus.a[gi] | bus.b[gi], bus.a[gi] & bus.b[gi]};
    assign result[gi] = lut[bus.op];
  end

  assign in_ready  = (count_q < CNT_W'(DEPTH));
  assign out_valid = (count_q != '0);
  assign accept    = bus.in_valid && in_ready;
  assign pop       = out_valid && bus.out_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (accept) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({accept, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is left unreset; the empty-gated read keeps stale data hidden.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem_q[wr_ptr_q] <= result;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.count     = count_q;
  assign bus.y         = out_valid ? mem_q[rd_ptr_q] : '0;

`ifdef GATE_PIPE_PARITY_EN
  logic par_mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (accept) begin
      par_mem_q[wr_ptr_q] <= ^result;
    end
  end

  assign bus.y_par = out_valid & par_mem_q[rd_ptr_q];
`endif
endmodule

// File: tb/tb_gate_pipe.sv
// Scoreboard bench for gate_pipe (WIDTH=2, DEPTH=4): directed vectors push
// hand-computed results; a monitor pops and compares on every consumed output.
module tb_gate_pipe;
  localparam int WIDTH = 2;
  localparam int DEPTH = 4;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;
  logic [WIDTH-1:0] cur_exp;
  logic [WIDTH:0]   sb[$];

  gate_pipe_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  gate_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach summary within time limit");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end else begin
      $display("ok   %s: %0h at %0t", name, act, $time);
    end
  endtask

  // Accept tracker: inputs only change just after posedge, so negedge sees
  // exactly what the next edge will sample.
  always @(negedge clk) begin
    if (!reset && bus.in_valid && bus.in_ready) begin
      sb.push_back({^cur_exp, cur_exp});
    end
  end

  always @(negedge clk) begin
    logic [WIDTH:0] exp_e;
    if (!reset) begin
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_pop", 64'(bus.y), 64'hDEAD);
        end else begin
          exp_e = sb.pop_front();
          check("y_order", 64'(bus.y), 64'(exp_e[WIDTH-1:0]));
`ifdef GATE_PIPE_PARITY_EN
          check("y_par", 64'(bus.y_par), 64'(exp_e[WIDTH]));
`endif
        end
      end else if (!bus.out_valid) begin
        check("y_idle_zero", 64'(bus.y), 64'd0);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] av, input logic [1:0] bv,
                      input logic [1:0] opv, input logic [1:0] ev);
    bus.a = av; bus.b = bv; bus.op = opv; cur_exp = ev;
    bus.in_valid = 1'b1;
    cyc();
    bus.in_valid = 1'b0;
    // Scramble operands after the accept edge; stored results must not move.
    bus.a = ~av; bus.b = ~bv; bus.op = opv + 2'd1;
  endtask

  task automatic drain(input int n);
    bus.out_ready = 1'b1;
    repeat (n) cyc();
    bus.out_ready = 1'b0;
  endtask

  logic [7:0] vec [10];

  initial begin
    // {a, b, op, expected}
    vec[0] = {2'b00, 2'b00, 2'b11, 2'b11};
    vec[1] = {2'b01, 2'b10, 2'b00, 2'b00};
    vec[2] = {2'b01, 2'b10, 2'b01, 2'b11};
    vec[3] = {2'b01, 2'b11, 2'b10, 2'b10};
    vec[4] = {2'b11, 2'b11, 2'b11, 2'b00};
    vec[5] = {2'b10, 2'b01, 2'b01, 2'b11};
    vec[6] = {2'b11, 2'b10, 2'b00, 2'b10};
    vec[7] = {2'b01, 2'b01, 2'b10, 2'b00};
    vec[8] = {2'b00, 2'b01, 2'b11, 2'b11};
    vec[9] = {2'b10, 2'b10, 2'b01, 2'b10};

    n_checks = 0; n_fail = 0; cur_exp = '0;
    reset = 1'b1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.a = '0; bus.b = '0; bus.op = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_count", 64'(bus.count), 64'd0);
    check("rst_y", 64'(bus.y), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Single accept into empty buffer, visible one cycle later.
    send(2'b11, 2'b01, 2'b00, 2'b01);
    @(negedge clk);
    check("lat_y", 64'(bus.y), 64'h1);
    check("lat_out_valid", 64'(bus.out_valid), 64'd1);
    check("lat_count", 64'(bus.count), 64'd1);
    @(posedge clk); #1;
    drain(1);

    // Fill with all four ops.
    send(2'b10, 2'b11, 2'b00, 2'b10);
    send(2'b10, 2'b11, 2'b01, 2'b11);
    send(2'b10, 2'b11, 2'b10, 2'b01);
    send(2'b10, 2'b11, 2'b11, 2'b01);
    @(negedge clk);
    check("full_count", 64'(bus.count), 64'd4);
    check("full_in_ready", 64'(bus.in_ready), 64'd0);
    check("full_head", 64'(bus.y), 64'h2);
    @(posedge clk); #1;

    // Full: offered operand must be ignored while one entry pops.
    bus.a = 2'b01; bus.b = 2'b01; bus.op = 2'b10; cur_exp = 2'b00;
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    cyc();
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    @(negedge clk);
    check("fullpop_count", 64'(bus.count), 64'd3);
    check("fullpop_in_ready", 64'(bus.in_ready), 64'd1);
    check("fullpop_head", 64'(bus.y), 64'h3);
    @(posedge clk); #1;
    // Over-drain: out_ready on an empty buffer must not underflow.
    drain(5);
    @(negedge clk);
    check("empty_count", 64'(bus.count), 64'd0);
    check("empty_out_valid", 64'(bus.out_valid), 64'd0);
    check("empty_in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;

    // Steady state at count=2 with simultaneous accept and pop.
    send(2'b11, 2'b01, 2'b01, 2'b11);
    send(2'b11, 2'b01, 2'b10, 2'b10);
    for (int i = 0; i < 10; i++) begin
      bus.a = vec[i][7:6]; bus.b = vec[i][5:4]; bus.op = vec[i][3:2];
      cur_exp = vec[i][1:0];
      bus.in_valid = 1'b1; bus.out_ready = 1'b1;
      @(negedge clk);
      check("steady_count", 64'(bus.count), 64'd2);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    @(negedge clk);
    check("steady_end_count", 64'(bus.count), 64'd2);
    @(posedge clk); #1;
    drain(2);

    // Parity-relevant vectors.
    send(2'b01, 2'b00, 2'b01, 2'b01);
    send(2'b01, 2'b00, 2'b00, 2'b00);
    drain(2);

    // Asynchronous reset mid-operation with count=3.
    send(2'b11, 2'b11, 2'b00, 2'b11);
    send(2'b11, 2'b00, 2'b01, 2'b11);
    send(2'b10, 2'b00, 2'b10, 2'b10);
    @(negedge clk);
    check("pre_rst_count", 64'(bus.count), 64'd3);
    #2;
    reset = 1'b1;
    bus.a = 2'b11; bus.b = 2'b11; bus.op = 2'b00; cur_exp = 2'b11;
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    sb.delete();
    #1;
    check("arst_out_valid", 64'(bus.out_valid), 64'd0);
    check("arst_y", 64'(bus.y), 64'd0);
    check("arst_count", 64'(bus.count), 64'd0);
    check("arst_in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    // First accept on the very first edge after reset release.
    send(2'b01, 2'b10, 2'b10, 2'b11);
    @(negedge clk);
    check("post_rst_count", 64'(bus.count), 64'd1);
    check("post_rst_y", 64'(bus.y), 64'h3);
    @(posedge clk); #1;
    drain(1);

    repeat (3) @(posedge clk);
    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/gate_pipe.md
GATE_PIPE -- requirements
Module: gate_pipe

Interface
REQ-001 Parameter WIDTH, default 2, operand and result bit width (legal 1..64).
REQ-002 Parameter DEPTH, default 4, result-buffer entries (power of two, legal 2..64).
REQ-003 Port clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 Port reset  input  1  asynchronous, active-high reset.
REQ-005 Port in_valid  input  1  operand set on a/b/op is valid.
REQ-006 Port in_ready  output  1  block SHALL accept operands this cycle.
REQ-007 Port a  input  WIDTH  operand A.
REQ-008 Port b  input  WIDTH  operand B.
REQ-009 Port op  input  2  operation select: 00 AND, 01 OR, 10 XOR, 11 NAND.
REQ-010 Port out_valid  output  1  y holds a buffered result.
REQ-011 Port out_ready  input  1  consumer takes y this cycle.
REQ-012 Port y  output  WIDTH  oldest buffered result.
REQ-013 Port count  output  $clog2(DEPTH)+1  number of buffered results.

Function
REQ-014 Accept: when in_valid && in_ready at a clk edge, the block SHALL compute op(a,b) bitwise over WIDTH bits and write it to the buffer tail.
REQ-015 op, a and b SHALL be sampled only at the accept edge; later changes SHALL NOT affect stored entries.
REQ-016 Pop: when out_valid && out_ready at a clk edge, the head entry SHALL be removed.
REQ-017 Latency: a result accepted into an empty buffer SHALL appear on y with out_valid=1 in the cycle after the accept edge; no combinational in-to-out path.
REQ-018 Show-ahead: y SHALL always present the head entry; y SHALL be all-zero while out_valid=0.
REQ-019 in_ready SHALL equal (count < DEPTH) and SHALL depend only on registered state (no out_ready path).
REQ-020 out_valid SHALL equal (count != 0).
REQ-021 Ordering: results SHALL leave in acceptance order.
REQ-022 Simultaneous accept and pop with 0 < count < DEPTH: count unchanged, both pointers advance.
REQ-023 Full (count=DEPTH): in_ready=0, in_valid ignored even if out_ready=1 that cycle; in_ready returns to 1 the cycle after a pop.
REQ-024 Empty (count=0): out_ready ignored; count SHALL NOT underflow.
REQ-025 Read and write pointers SHALL wrap modulo DEPTH with no lost or duplicated entry.
REQ-026 count SHALL increment on accept-only, decrement on pop-only, hold otherwise.

Reset
REQ-027 Asserting reset SHALL immediately (asynchronously) clear count, both pointers and out_valid, and force y to 0 and in_ready to 1.
REQ-028 Reset mid-operation SHALL discard all buffered entries; an accept or pop coinciding with the reset edge SHALL have no effect.
REQ-029 Buffer storage need not be reset; its contents SHALL be unobservable while empty.
REQ-030 First accept SHALL be possible on the first clk edge after reset deasserts.

Configuration
REQ-031 Macro GATE_PIPE_PARITY_EN defined: add port y_par  output  1, even parity (XOR-reduce) of the result computed at accept and stored with the entry, presented alongside y, 0 when out_valid=0.
REQ-032 Macro GATE_PIPE_PARITY_EN undefined: port y_par and its storage SHALL not exist; all other behaviour identical.

Verification (WIDTH=2, DEPTH=4)
REQ-033 Reset then a=2'b11,b=2'b01,op=00 accepted, out_ready=0 -> next cycle y=2'b01, out_valid=1, count=1.
REQ-034 Four accepts of ops 00,01,10,11 on a=2'b10,b=2'b11, out_ready=0 -> count=4, in_ready=0; then drain gives y=10,11,01,01 in order.
REQ-035 Full buffer, in_valid=1, out_ready=1 one cycle -> one pop, no accept, count=3, in_ready=1 next cycle.
REQ-036 count=2, accept and pop same edge, repeated 10 cycles -> count stays 2, pointers wrap, results in order with none lost.
REQ-037 count=3, assert reset between edges -> out_valid=0, y=0, count=0, in_ready=1 before next edge.
REQ-038 With GATE_PIPE_PARITY_EN, a=2'b01,b=2'b00,op=01 accepted -> y=2'b01, y_par=1; op=00 -> y=2'b00, y_par=0.
